// File: rtl/pwm_gen_pkg.sv
// Shared definitions for the PWM generator bank: command word bit layout and
// the decoded per-channel mode bits.
package pwm_gen_pkg;

    localparam int MAG_LSB   = 0;
    localparam int UPINV_BIT = 12;
    localparam int DNINV_BIT = 13;
    localparam int PDM_BIT   = 14;
    localparam int DIR_BIT   = 15;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_e;

    // Mode flags carried in the upper nibble of a command word.
    typedef struct packed {
        dir_e dir;
        logic pdm;
        logic dn_inv;
        logic up_inv;
    } mode_t;

    function automatic mode_t decode_mode(input logic [15:0] word);
        mode_t m;
        m.dir    = dir_e'(word[DIR_BIT]);
        m.pdm    = word[PDM_BIT];
        m.dn_inv = word[DNINV_BIT];
        m.up_inv = word[UPINV_BIT];
        return m;
    endfunction

endpackage

// File: rtl/pwm_gen_chan.sv
// One PWM/PDM channel: double-buffered command, direction-change deadtime and
// registered forward/reverse drive outputs.
module pwm_gen_chan
    import pwm_gen_pkg::*;
#(
    parameter int PW  = 11,
    parameter int DTW = 4,
    parameter int DT  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [15:0]   data,
    input  logic          wrap,
    input  logic          halt,
    input  logic [PW-1:0] cnt,
    input  logic [PW-1:0] pdm_cmp,
    output logic          up,
    output logic          down
);

    // The deadtime includes the load clock itself, so the counter holds DT-1 more.
    localparam logic [DTW-1:0] DT_RELOAD = (DT > 0) ? DTW'(DT - 1) : '0;

    mode_t          sh_mode, ac_mode, nx_mode, wr_mode;
    logic [PW-1:0]  sh_mag, ac_mag, nx_mag, wr_mag, cmp;
    logic [DTW-1:0] dt_cnt;
    logic           dir_chg, dt_start, gate, act;
    logic           unused_data;

    // Bits between the magnitude field and the mode nibble carry no meaning.
    assign unused_data = ^data;

    assign wr_mode = decode_mode(data);
    assign wr_mag  = data[MAG_LSB +: PW];

    // A write landing on the wrap clock bypasses the shadow straight into active.
    assign nx_mode = wr ? wr_mode : sh_mode;
    assign nx_mag  = wr ? wr_mag  : sh_mag;

    assign dir_chg  = wrap && (nx_mode.dir != ac_mode.dir);
    assign dt_start = dir_chg && (DT != 0);
    assign gate     = halt || dt_start || (dt_cnt != '0);

    assign cmp = ac_mode.pdm ? pdm_cmp : cnt;
    assign act = !gate && (ac_mag > cmp);

    // Shadow takes every write; active follows it at the period wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_mode <= '0;
            sh_mag  <= '0;
            ac_mode <= '0;
            ac_mag  <= '0;
        end else begin
            if (wr) begin
                sh_mode <= wr_mode;
                sh_mag  <= wr_mag;
            end
            if (wrap) begin
                ac_mode <= nx_mode;
                ac_mag  <= nx_mag;
            end
        end
    end

    // Deadtime countdown, restarted by every direction change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dt_cnt <= '0;
        end else if (dt_start) begin
            dt_cnt <= DT_RELOAD;
        end else if (dt_cnt != '0) begin
            dt_cnt <= dt_cnt - 1'b1;
        end
    end

    // Drive outputs: direction steers act, invert bits set the idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up   <= 1'b0;
            down <= 1'b0;
        end else begin
            up   <= ac_mode.up_inv ^ (act && (ac_mode.dir == DIR_FWD));
            down <= ac_mode.dn_inv ^ (act && (ac_mode.dir == DIR_REV));
        end
    end

endmodule

// File: rtl/pwm_gen_bank.sv
// Bank of PWM/PDM channels sharing one free-running period counter and a
// command/kick watchdog that idles every channel when it trips.
module pwm_gen_bank
    import pwm_gen_pkg::*;
#(
    parameter  int NCH = 4,
    parameter  int PW  = 11,
    parameter  int DTW = 4,
    parameter  int DT  = 8,
    parameter  int WDW = 16,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_wr,
    input  logic [CHW-1:0] cmd_ch,
    input  logic [15:0]    cmd_data,
    input  logic           wd_kick,
    input  logic           wd_clear,
    input  logic [WDW-1:0] wd_limit,
    output logic [NCH-1:0] up,
    output logic [NCH-1:0] down,
    output logic           at_top,
    output logic           wd_tripped
);

    localparam logic [PW-1:0] CNT_MAX = '1;

    logic [PW-1:0]  cnt, pdm_cmp;
    logic [WDW-1:0] wd_cnt;
    logic           wrap;

    // PDM ordering: bit-reverse the bits above the low nibble so high time is
    // spread across the period in 16-clock slices.
    function automatic logic [PW-1:0] pdm_order(input logic [PW-1:0] c);
        logic [PW-1:0] r;
        r = c;
        for (int b = 4; b < PW; b++) begin
            r[b] = c[PW - 1 - (b - 4)];
        end
        return r;
    endfunction

    assign wrap    = (cnt == CNT_MAX);
    assign pdm_cmp = pdm_order(cnt);

    // Period counter; at_top is registered one clock early so it lines up with cnt==max.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            at_top <= 1'b0;
        end else begin
            cnt    <= cnt + 1'b1;
            at_top <= (cnt == CNT_MAX - 1'b1);
        end
    end

    // Watchdog: any command or kick restarts it; only wd_clear releases a trip.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt     <= '0;
            wd_tripped <= 1'b0;
        end else if (wd_clear) begin
            wd_cnt     <= '0;
            wd_tripped <= 1'b0;
        end else begin
            if (wd_kick || cmd_wr) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if ((wd_limit != '0) && (wd_cnt >= wd_limit)) begin
                wd_tripped <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        pwm_gen_chan #(
            .PW  (PW),
            .DTW (DTW),
            .DT  (DT)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .wr      (cmd_wr && (cmd_ch == CHW'(i))),
            .data    (cmd_data),
            .wrap    (wrap),
            .halt    (wd_tripped),
            .cnt     (cnt),
            .pdm_cmp (pdm_cmp),
            .up      (up[i]),
            .down    (down[i])
        );
    end

endmodule

// File: tb/tb_pwm_gen_bank.sv
// Self-checking bench for pwm_gen_bank: directed scenarios plus randomized
// traffic, compared every clock against a timestamp-based behavioural model.
module tb_pwm_gen_bank;

    localparam int NCH    = 4;
    localparam int PW     = 11;
    localparam int DTW    = 4;
    localparam int DT     = 8;
    localparam int WDW    = 16;
    localparam int CHW    = 2;
    localparam int PERIOD = 1 << PW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cmd_wr = 1'b0;
    logic [CHW-1:0] cmd_ch = '0;
    logic [15:0]    cmd_data = '0;
    logic           wd_kick = 1'b0;
    logic           wd_clear = 1'b0;
    logic [WDW-1:0] wd_limit = '0;
    logic [NCH-1:0] up, down;
    logic           at_top, wd_tripped;

    pwm_gen_bank #(
        .NCH (NCH),
        .PW  (PW),
        .DTW (DTW),
        .DT  (DT),
        .WDW (WDW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_wr     (cmd_wr),
        .cmd_ch     (cmd_ch),
        .cmd_data   (cmd_data),
        .wd_kick    (wd_kick),
        .wd_clear   (wd_clear),
        .wd_limit   (wd_limit),
        .up         (up),
        .down       (down),
        .at_top     (at_top),
        .wd_tripped (wd_tripped)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: time is an absolute clock index since reset; deadtime
    // and watchdog are tracked as timestamps rather than counters.
    logic [15:0]    m_shadow [NCH];
    logic [15:0]    m_active [NCH];
    int             m_gap_end[NCH];
    int             m_t;
    int             m_wd_zero;
    bit             m_trip;
    logic [NCH-1:0] exp_up, exp_down;
    bit             exp_top, exp_trip;

    int hi_up[NCH];
    int dn0, run1, max_run1, z0, max_z0;

    function automatic int pdm_compare(input int c);
        int upper, rev;
        upper = c / 16;
        rev   = 0;
        for (int b = 0; b < PW - 4; b++) begin
            if (((upper >> b) & 1) == 1) rev += 1 << (PW - 5 - b);
        end
        return rev * 16 + c % 16;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_shadow[i]  = '0;
            m_active[i]  = '0;
            m_gap_end[i] = 0;
        end
        m_t       = 0;
        m_wd_zero = 0;
        m_trip    = 1'b0;
        exp_up    = '0;
        exp_down  = '0;
        exp_top   = 1'b0;
        exp_trip  = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_step();
        int          c, mag, cmp, wd_count;
        bit          wrap, gated, act, dir, hit;
        logic [15:0] nv;
        c    = m_t % PERIOD;
        wrap = (c == PERIOD - 1);
        for (int i = 0; i < NCH; i++) begin
            hit = cmd_wr && (int'(cmd_ch) == i);
            nv  = hit ? cmd_data : m_shadow[i];
            if (wrap && DT > 0 && nv[15] != m_active[i][15]) m_gap_end[i] = m_t + DT;
            gated = m_trip || (m_t < m_gap_end[i]);
            mag   = int'(m_active[i][PW-1:0]);
            cmp   = m_active[i][14] ? pdm_compare(c) : c;
            act   = !gated && (mag > cmp);
            dir   = m_active[i][15];
            exp_up[i]   = m_active[i][12] ^ (act && !dir);
            exp_down[i] = m_active[i][13] ^ (act && dir);
            if (hit)  m_shadow[i] = cmd_data;
            if (wrap) m_active[i] = nv;
        end
        wd_count = m_t - m_wd_zero;
        if (wd_clear) m_trip = 1'b0;
        else if (wd_limit != '0 && wd_count >= int'(wd_limit)) m_trip = 1'b1;
        if (wd_clear || wd_kick || cmd_wr) m_wd_zero = m_t + 1;
        exp_trip = m_trip;
        exp_top  = (((m_t + 1) % PERIOD) == PERIOD - 1);
        m_t++;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NCH; i++) hi_up[i] = 0;
        dn0 = 0; run1 = 0; max_run1 = 0; z0 = 0; max_z0 = 0;
    endtask

    // One clock: model across the edge, then compare on the falling edge.
    task automatic cycle();
        model_step();
        @(negedge clk);
        chk("up",         32'(up),         32'(exp_up));
        chk("down",       32'(down),       32'(exp_down));
        chk("at_top",     32'(at_top),     32'(exp_top));
        chk("wd_tripped", 32'(wd_tripped), 32'(exp_trip));
        for (int i = 0; i < NCH; i++) if (up[i]) hi_up[i]++;
        if (down[0]) dn0++;
        if (up[1]) run1++; else run1 = 0;
        if (run1 > max_run1) max_run1 = run1;
        if (!up[0] && !down[0]) z0++; else z0 = 0;
        if (z0 > max_z0) max_z0 = z0;
        cmd_wr   = 1'b0;
        wd_kick  = 1'b0;
        wd_clear = 1'b0;
    endtask

    task automatic write(input int ch, input logic [15:0] data);
        cmd_wr   = 1'b1;
        cmd_ch   = CHW'(ch);
        cmd_data = data;
        cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic until_count(input int c);
        while ((m_t % PERIOD) != c) cycle();
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_up",   32'(up),         0);
        chk("rst_async_down", 32'(down),       0);
        chk("rst_async_top",  32'(at_top),     0);
        chk("rst_async_trip", 32'(wd_tripped), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        clear_stats();
        repeat (2) @(negedge clk);
        chk("reset_up",   32'(up),         0);
        chk("reset_down", 32'(down),       0);
        chk("reset_top",  32'(at_top),     0);
        chk("reset_trip", 32'(wd_tripped), 0);
        rst = 1'b0;

        // PWM at 512 on ch0, PDM at 1024 on ch1.
        write(0, 16'd512);
        write(1, 16'h4000 | 16'd1024);
        idle(PERIOD + 50);
        clear_stats();
        idle(PERIOD);
        chk("pwm_duty",   32'(hi_up[0]), 512);
        chk("pwm_down",   32'(dn0),      0);
        chk("pdm_duty",   32'(hi_up[1]), 1024);
        chk("pdm_maxrun", 32'(max_run1), 16);

        // Mid-period write waits for the wrap; at_top write applies next period.
        until_count(100);
        write(0, 16'd1500);
        until_count(PERIOD - 1);
        write(2, 16'd300);
        clear_stats();
        idle(PERIOD - 1);
        chk("midperiod_duty", 32'(hi_up[0]), 1500);
        chk("attop_duty",     32'(hi_up[2]), 300);

        // Direction change with full magnitude.
        write(0, 16'd2047);
        until_count(1000);
        write(0, 16'h8000 | 16'd2047);
        clear_stats();
        until_count(100);
        chk("deadtime_gap", 32'(max_z0),  DT);
        chk("rev_down",     32'(down[0]), 1);
        chk("rev_up",       32'(up[0]),   0);

        // Watchdog trip with up inverted, then clear.
        wd_limit = 16'd1000;
        write(0, 16'h1000 | 16'd512);
        idle(2100);
        chk("wd_trip",      32'(wd_tripped), 1);
        chk("wd_up_idle",   32'(up[0]),      1);
        chk("wd_down_idle", 32'(down[0]),    0);
        wd_clear = 1'b1;
        wd_limit = '0;
        cycle();
        chk("wd_cleared", 32'(wd_tripped), 0);
        idle(PERIOD + 10);

        // Clear coinciding with the trip condition wins.
        wd_limit = 16'd3;
        wd_clear = 1'b1;
        cycle();
        idle(3);
        wd_clear = 1'b1;
        cycle();
        chk("clear_wins", 32'(wd_tripped), 0);
        idle(5);

        // Randomized traffic.
        wd_limit = 16'd700;
        repeat (8000) begin
            cmd_wr   = ($urandom_range(0, 599) == 0);
            if ((m_t % PERIOD) == PERIOD - 1 && $urandom_range(0, 3) == 0) cmd_wr = 1'b1;
            cmd_ch   = CHW'($urandom_range(0, NCH - 1));
            cmd_data = 16'($urandom);
            wd_kick  = ($urandom_range(0, 1499) == 0);
            wd_clear = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 1999) == 0) wd_limit = WDW'($urandom_range(0, 1200));
            cycle();
        end

        // Asynchronous reset mid-period.
        wd_limit = '0;
        write(3, 16'd1800);
        idle(PERIOD);
        until_count(700);
        pulse_reset();
        idle(PERIOD + 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
